// File: rtl/proc_out_serializer.sv
// rtl/proc_out_serializer.sv - buffers 16-bit processor results and emits them MSB-first as a byte stream
module proc_out_serializer #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          system1000,
  input  logic          system1000_rst,
  input  logic          oEn,
  input  logic [15:0]   POut,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [15:0]   hr;
  logic [15:0]   head;
  logic          has_data;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign head     = mem[rptr];
  assign has_data = (count != '0);
  assign full     = (count == FULL);
  // A full FIFO may still take a word when the serializer pops in the same cycle.
  assign pop      = has_data && ((state == IDLE) || (state == LO && tx_ready));
  assign push     = oEn && (!full || pop);
  assign drop     = oEn && full && !pop;
  assign level    = count;

  // Storage needs no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge system1000) begin
    if (push) mem[wptr] <= POut;
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      hr       <= 16'h0000;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'h0000;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (clr_ovf) begin
        overflow <= drop;
        drop_cnt <= drop ? 16'h0001 : 16'h0000;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h0001;
      end

      case (state)
        IDLE: begin
          tx_valid <= 1'b0;
          if (has_data) begin
            hr       <= head;
            tx_data  <= head[15:8];
            tx_valid <= 1'b1;
            state    <= HI;
          end
        end
        HI: begin
          if (tx_ready) begin
            tx_data <= hr[7:0];
            state   <= LO;
          end
        end
        LO: begin
          if (tx_ready) begin
            if (has_data) begin
              hr      <= head;
              tx_data <= head[15:8];
              state   <= HI;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_out_serializer.sv
// tb/tb_proc_out_serializer.sv - randomized self-checking bench against a queue-based reference model
module tb_proc_out_serializer;

  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          oEn;
  logic [15:0]   POut;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW:0]   level;
  logic          overflow;
  logic          clr_ovf;
  logic [15:0]   drop_cnt;

  proc_out_serializer #(.DEPTH(DEPTH)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .oEn            (oEn),
    .POut           (POut),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .level          (level),
    .overflow       (overflow),
    .clr_ovf        (clr_ovf),
    .drop_cnt       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference: words waiting in the buffer, and bytes still owed by the word being sent.
  logic [15:0] q[$];
  logic [7:0]  sb[$];
  logic        m_ovf;
  logic [15:0] m_cnt;
  int          peak_dut;
  int          peak_ref;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    sb.delete();
    m_ovf = 1'b0;
    m_cnt = 16'h0000;
  endtask

  task automatic compare_all();
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, sb.size() > 0});
    if (sb.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, sb[0]});
    chk("level", {27'd0, level}, q.size());
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_cnt});
  endtask

  task automatic step(input logic oe, input logic [15:0] pv, input logic rdy, input logic clr);
    logic acc, pop, push, drop;
    logic [15:0] w;
    oEn = oe; POut = pv; tx_ready = rdy; clr_ovf = clr;
    acc  = (sb.size() > 0) && rdy;
    pop  = (q.size() > 0) && ((sb.size() == 0) || (sb.size() == 1 && acc));
    push = oe && ((q.size() < DEPTH) || pop);
    drop = oe && !push;
    @(posedge clk); #1;
    if (acc) void'(sb.pop_front());
    if (pop) begin
      w = q.pop_front();
      sb.push_back(w[15:8]);
      sb.push_back(w[7:0]);
    end
    if (push) q.push_back(pv);
    if (clr) begin
      m_ovf = drop;
      m_cnt = drop ? 16'h0001 : 16'h0000;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
    end
    if (int'(level) > peak_dut) peak_dut = int'(level);
    if (q.size() > peak_ref) peak_ref = q.size();
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() > 0 || q.size() > 0); i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drain_done", {31'd0, (sb.size() > 0 || q.size() > 0)}, 32'd0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; oEn = 1'b0; POut = 16'h0; tx_ready = 1'b0; clr_ovf = 1'b0;
    peak_dut = 0; peak_ref = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_dcnt", {16'd0, drop_cnt}, 32'd0);
    rst = 1'b0;

    // Single word with latency check
    step(1'b1, 16'hA5C3, 1'b1, 1'b0);
    chk("lat_n1_valid", {31'd0, tx_valid}, 32'd0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("lat_n2_valid", {31'd0, tx_valid}, 32'd1);
    chk("lat_hi", {24'd0, tx_data}, 32'hA5);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("single_lo", {24'd0, tx_data}, 32'hC3);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("single_idle", {31'd0, tx_valid}, 32'd0);

    // Backpressure on a negative value
    step(1'b1, 16'hFFFE, 1'b0, 1'b0);
    repeat (5) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("bp_hold", {24'd0, tx_data}, 32'hFF);
    drain();

    // Burst 0..7 without stall
    peak_dut = 0; peak_ref = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    drain();
    chk("burst_peak", peak_dut, peak_ref);
    chk("burst_ovf", {31'd0, overflow}, 32'd0);

    // Overflow: DEPTH+1+3 words with the link stalled
    for (int i = 0; i < DEPTH + 4; i++) step(1'b1, 16'h100 + 16'(i), 1'b0, 1'b0);
    chk("ovf_level", {27'd0, level}, DEPTH);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_dcnt", {16'd0, drop_cnt}, 32'd3);
    drain();

    // Full FIFO accepts a word when the low byte is taken the same cycle
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 16'h200 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("race_level", {27'd0, level}, DEPTH);
    chk("race_nodrop", {31'd0, overflow}, 32'd0);
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    chk("pre_clr_dcnt", {16'd0, drop_cnt}, 32'd2);
    step(1'b1, 16'h3333, 1'b0, 1'b1);
    chk("clr_race_ovf", {31'd0, overflow}, 32'd1);
    chk("clr_race_dcnt", {16'd0, drop_cnt}, 32'd1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 60), 16'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 31) == 0));
    drain();

    // Reset in the middle of a word
    for (int i = 0; i < 6; i++) step(1'b1, 16'h300 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre_rst_level", {27'd0, level}, 32'd5);
    rst = 1'b1;
    #2;
    chk("async_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("async_rst_level", {27'd0, level}, 32'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_hi", {24'd0, tx_data}, 32'h12);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_lo", {24'd0, tx_data}, 32'h34);
    drain();
    chk("post_rst_idle", {31'd0, tx_valid}, 32'd0);

    do_reset();
    chk("final_level", {27'd0, level}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
